// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the divider: func[1:0] operation encodings,
// iteration count, divider FSM state type and a sign-fixup helper.
package cpu_pkg;

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  localparam int unsigned DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } div_state_t;

  // Two's-complement negate when neg is set; used for |x| and result sign fix-up
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, trial-subtract
// the divisor using a 33-bit compare, keep the difference when it fits.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvsr,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);
  import cpu_pkg::*;

  logic [32:0] shifted;
  logic [31:0] diff;
  logic        fits;

  // Shift, compare and conditionally subtract
  always_comb begin
    shifted = {rem, quo[31]};
    fits    = (shifted >= {1'b0, dvsr});
    diff    = shifted[31:0] - dvsr;
    if (fits) begin
      rem_next = diff;
      quo_next = {quo[30:0], 1'b1};
    end else begin
      rem_next = shifted[31:0];
      quo_next = {quo[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional feature macro: DIV_EARLY_OUT_EN -- divide-by-zero and signed
// overflow skip CALC and go straight to FINISH with the result preloaded.
module div_unit (
  input  logic        aclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  func,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] dout
);
  import cpu_pkg::*;

  div_state_t  state, state_next;
  logic [4:0]  cnt;
  logic [1:0]  op;
  logic        q_neg, r_neg;
  logic        sp_zero, sp_ovf;
  logic [31:0] rem, quo, dvsr;
  logic [31:0] rem_next, quo_next;
  logic [31:0] dout_r;
  logic        done_r;

  logic        launch;
  logic        is_signed;
  logic        in_zero, in_ovf;
  logic        early_hit;
  logic [31:0] a_abs, b_abs;
  logic [31:0] q_fix, r_fix, result;
  logic        func_unused;

  // func[2] is always 1 from the decoder and carries no information
  assign func_unused = func[2];

  div_step u_step (
    .rem      (rem),
    .quo      (quo),
    .dvsr     (dvsr),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Launch decode: operand magnitudes and special-case detection
  always_comb begin
    launch    = (state == IDLE) && start && !flush;
    is_signed = !func[0];
    a_abs     = is_signed ? neg_if(din1[31], din1) : din1;
    b_abs     = is_signed ? neg_if(din2[31], din2) : din2;
    in_zero   = (din2 == '0);
    in_ovf    = is_signed && (din1 == 32'h8000_0000) && (din2 == '1);
`ifdef DIV_EARLY_OUT_EN
    early_hit = in_zero || in_ovf;
`else
    early_hit = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (launch) state_next = early_hit ? FINISH : CALC;
      CALC:   if (flush) state_next = IDLE;
              else if (cnt == 5'(DIV_ITERS - 1)) state_next = FINISH;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs derived from registered state only
  always_comb begin
    busy = (state != IDLE);
    done = done_r;
    dout = dout_r;
  end

  // Sign fix-up and RISC-V special-case override; the natural datapath already
  // yields rem = din1 for divide-by-zero, so only the quotient is forced there
  always_comb begin
    q_fix  = neg_if(q_neg, quo);
    r_fix  = neg_if(r_neg, rem);
    if (sp_zero) q_fix = '1;
    if (sp_ovf) begin
      q_fix = 32'h8000_0000;
      r_fix = '0;
    end
    result = op[1] ? r_fix : q_fix;
  end

  // Operand capture, iteration datapath, counter and result register
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op      <= DIV_OP;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      sp_zero <= 1'b0;
      sp_ovf  <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      dout_r  <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (launch) begin
            op      <= func[1:0];
            sp_zero <= in_zero;
            sp_ovf  <= in_ovf;
            dvsr    <= b_abs;
            if (early_hit) begin
              quo   <= in_zero ? '1 : 32'h8000_0000;
              rem   <= in_zero ? din1 : '0;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end else begin
              quo   <= a_abs;
              rem   <= '0;
              q_neg <= is_signed && (din1[31] ^ din2[31]);
              r_neg <= is_signed && din1[31];
            end
          end
        end
        CALC: begin
          if (flush) begin
            cnt <= '0;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 5'd1;
          end
        end
        FINISH: begin
          cnt <= '0;
          if (!flush) begin
            dout_r <= result;
            done_r <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a cycle-level behavioural model predicts
// busy/done/dout every cycle; directed vectors carry hand-computed results.
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SP = 1;
`else
  localparam int LAT_SP = 33;
`endif
  localparam int LAT = 33;

  logic        aclk;
  logic        rst_n;
  logic        start;
  logic [2:0]  func;
  logic [31:0] din1, din2;
  logic        flush;
  logic        busy, done;
  logic [31:0] dout;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  div_unit dut (
    .aclk  (aclk),
    .rst_n (rst_n),
    .start (start),
    .func  (func),
    .din1  (din1),
    .din2  (din2),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // RISC-V reference result
  function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    logic want_rem;
    sgn      = !f[0];
    want_rem = f[1];
    if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return want_rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return want_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return want_rem ? a % b : a / b;
  endfunction

  function automatic logic is_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Behavioural model: busy countdown from the accepted start edge
  logic        m_busy, m_done;
  logic [31:0] m_dout, m_res;
  int          m_left;

  always @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dout <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (flush) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_done <= 1'b1;
          m_dout <= m_res;
          m_busy <= 1'b0;
        end else m_left <= m_left - 1;
      end else if (start && !flush) begin
        m_res  <= ref_result(func[1:0], din1, din2);
        m_busy <= 1'b1;
        m_left <= is_special(func[1:0], din1, din2) ? LAT_SP : LAT;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge aclk) begin
    if (chk_en) begin
      n_cmp++;
      if (busy !== m_busy || done !== m_done || dout !== m_dout) begin
        n_err++;
        $display("FAIL cycle_model t=%0t busy/done/dout got %b/%b/%h exp %b/%b/%h",
                 $time, busy, done, dout, m_busy, m_done, m_dout);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // Drive a start pulse; caller is at a negedge, returns at the next negedge
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    func  = f;
    din1  = a;
    din2  = b;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int lat, output logic ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (done) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic ok;
    issue(f, a, b);
    wait_done(40, lat, ok);
    check({nm, "_done_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check(nm, dout, exp);
      check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    end
  endtask

  initial begin
    int   lat;
    logic ok;
    int   dones;

    start = 1'b0;
    func  = 3'b101;
    din1  = '0;
    din2  = '0;
    flush = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dout", dout, 32'd0);

    // Basic unsigned
    do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, LAT);

    // Flush at cycle 10: busy drops, no done, dout holds 14
    issue(3'b101, 32'd1000, 32'd10);
    repeat (9) @(negedge aclk);
    flush = 1'b1;
    @(negedge aclk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_dout_held", dout, 32'd14);
    dones = 0;
    repeat (40) begin
      @(negedge aclk);
      if (done) dones++;
    end
    check("flush_no_done", 32'(dones), 32'd0);

    do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, LAT);
    do_op("divu_1000_10", 3'b101, 32'd1000, 32'd10, 32'd100, LAT);
    do_op("div_m100_7", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, LAT);
    do_op("rem_m100_7", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT);
    do_op("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT);
    do_op("divu_big", 3'b101, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, LAT);
    do_op("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SP);
    do_op("remu_5_0", 3'b111, 32'd5, 32'd0, 32'd5, LAT_SP);
    do_op("rem_m5_0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_SP);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SP);
    do_op("divu_min_1s", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT);

    // Second start while busy is ignored
    issue(3'b100, 32'hFFFF_FF9C, 32'd7);
    repeat (4) @(negedge aclk);
    issue(3'b101, 32'd50, 32'd5);
    wait_done(40, lat, ok);
    check("busy_ign_done_seen", 32'(ok), 32'd1);
    check("busy_ign_result", dout, 32'hFFFF_FFF2);
    dones = 0;
    repeat (40) begin
      @(negedge aclk);
      if (done) dones++;
    end
    check("busy_ign_single_done", 32'(dones), 32'd0);

    // Asynchronous reset mid-operation
    issue(3'b101, 32'd1000, 32'd10);
    repeat (19) @(negedge aclk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_dout", dout, 32'd0);
    @(negedge aclk);
    #2 rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge aclk);
      if (done) dones++;
    end
    check("async_rst_no_done", 32'(dones), 32'd0);

    do_op("post_rst_divu", 3'b101, 32'd100, 32'd7, 32'd14, LAT);

    @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
